dff_mem_burst: RTL
==================

# dff_mem_burst

Parametrised flip-flop memory with an internal auto-incrementing address pointer, a valid/ready command port, registered reads and a self-timed bulk CLEAR. It replaces combinational latch-style RAM access with fully clocked behaviour. It sits behind the pin-level wrapper of a memory test tile, which maps pins onto the command port.

## Interface
Parameters:
- DATA_W, 8, word width in bits (1..32)
- DEPTH, 32, number of words (2..256; any value, power of 2 not required)
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command; equals !busy
- cmd_op  in  2  0 SET_ADDR, 1 WRITE, 2 READ, 3 CLEAR
- cmd_data  in  DATA_W  address (SET_ADDR, low ADDR_W bits) or write data (WRITE)
- wr_par_inv  in  1  test hook: invert the stored parity bit on WRITE (ignored without the parity macro)
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  one-cycle pulse; rd_data is valid
- rd_err  out  1  parity mismatch, qualified by rd_valid
- addr_err  out  1  one-cycle pulse; SET_ADDR value >= DEPTH was rejected
- ptr  out  ADDR_W  current pointer
- busy  out  1  CLEAR in progress

## Operation
- A command transfers on a rising edge where cmd_valid && cmd_ready. Commands presented while cmd_ready is low are ignored, not queued.
- SET_ADDR: if cmd_data < DEPTH, ptr <= cmd_data. Otherwise ptr is unchanged and addr_err pulses in the next cycle. The compare uses the full DATA_W value.
- WRITE: mem[ptr] <= cmd_data, then ptr advances.
- READ: rd_data <= mem[ptr], rd_valid pulses, then ptr advances.
- Pointer advance: if ptr == DEPTH-1, ptr becomes 0; otherwise ptr increments.
- CLEAR: the FSM moves IDLE -> CLEARING. It writes 0 to word k in the k-th cycle of CLEARING, for k = 0..DEPTH-1, then returns to IDLE with ptr = 0. The FSM has two states, IDLE and CLEARING, plus a clear counter of ADDR_W bits. Exit occurs at count DEPTH-1.
- rd_data holds its last value between reads.
- Reset values: ptr 0, rd_data 0, rd_valid 0, rd_err 0, addr_err 0, busy 0, FSM IDLE.
- Memory contents are not reset, so they are undefined after reset until written or cleared.
- Reset during CLEARING aborts immediately. Words already cleared stay 0; all other words keep their prior contents.

## Timing
- WRITE accepted in cycle N: the word updates at the end of cycle N. A READ of the same word in cycle N+1 returns the new value.
- READ accepted in cycle N: rd_data and rd_valid appear in cycle N+1. Back-to-back READs give one word per cycle.
- CLEAR accepted in cycle N: busy and CLEARING are high for cycles N+1..N+DEPTH, and cmd_ready is low for those cycles. A new command is accepted in cycle N+DEPTH+1 at the earliest.
- addr_err pulses in cycle N+1 for a bad SET_ADDR accepted in cycle N.
- No combinational path from cmd_* to any output except cmd_ready, which is driven from registered busy only.

## Configuration
- DFF_MEM_PARITY_EN defined:
  - Each word stores DATA_W+1 bits; the extra bit is even parity of the data, XOR wr_par_inv.
  - On READ, rd_err <= recomputed parity != stored parity, in the same cycle as rd_valid.
  - CLEAR writes parity bit 0.
- DFF_MEM_PARITY_EN undefined:
  - Words are DATA_W bits.
  - rd_err is constant 0 and wr_par_inv is unused.

## Structure
- Shared package dff_mem_pkg holds:
  - the cmd_op encoding as an enum (OP_SET_ADDR, OP_WRITE, OP_READ, OP_CLEAR)
  - the FSM state enum (ST_IDLE, ST_CLEARING)
- Sub-module dff_mem_array holds the storage: one write port, one registered read port, and the optional parity bit. The top level contains the pointer, FSM, handshake and error logic.

## Test plan
- Reset then idle: all outputs hold their reset values; cmd_ready = 1.
- SET_ADDR 3, WRITE 0xA5, WRITE 0x5A, SET_ADDR 3, READ, READ -> rd_data 0xA5 then 0x5A on consecutive cycles; ptr ends at 5.
- DEPTH = 20 with SET_ADDR 19, WRITE 0x11, READ -> ptr wraps to 0 after the WRITE, and the READ returns word 0. SET_ADDR 25 -> addr_err pulses and ptr is unchanged.
- CLEAR with DEPTH = 32:
  - busy and !cmd_ready for exactly 32 cycles
  - READs issued during those cycles are ignored
  - afterwards, reading all 32 words returns 0 and ptr = 0
- rst asserted mid-CLEAR at k = 10: words 0..9 read 0, and words 10..31 keep their pre-CLEAR values.
- With DFF_MEM_PARITY_EN: WRITE 0x3C with wr_par_inv = 1, then READ -> rd_valid = 1 and rd_err = 1. The same sequence with wr_par_inv = 0 gives rd_err = 0.

Source files
------------

// File: rtl/dff_mem_pkg.sv
// Shared types for the dff_mem_burst slice: command opcodes and the
// sequencer state encoding.
package dff_mem_pkg;

  typedef enum logic [1:0] {
    OP_SET_ADDR = 2'd0,
    OP_WRITE    = 2'd1,
    OP_READ     = 2'd2,
    OP_CLEAR    = 2'd3
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CLEARING = 1'b1
  } state_e;

endpackage

// File: rtl/dff_mem_array.sv
// Flip-flop storage for dff_mem_burst: one write port and one registered
// read port. Build option DFF_MEM_PARITY_EN adds a per-word even parity bit
// and a parity-mismatch flag on the read port.
module dff_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wpar_inv,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err
);

`ifdef DFF_MEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] wword;
  logic [WORD_W-1:0] rword;

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;

  // Build the stored word; the parity bit sits above the data bits.
  always_comb begin
`ifdef DFF_MEM_PARITY_EN
    wword = {(^wdata) ^ wpar_inv, wdata};
`else
    wword = wdata;
`endif
  end

  // Storage is deliberately not reset so a reset mid-clear leaves words intact.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wword;
    end
  end

  assign rword = mem_q[raddr];

  // Read data holds between reads; valid is a single-cycle pulse.
  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = re;
    if (re) begin
      rd_data_d = rword[DATA_W-1:0];
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

`ifdef DFF_MEM_PARITY_EN
  logic rd_err_q, rd_err_d;

  // Flag a mismatch between recomputed and stored parity, only with valid.
  always_comb begin
    rd_err_d = 1'b0;
    if (re) begin
      rd_err_d = (^rword[DATA_W-1:0]) != rword[DATA_W];
    end
  end

  // Error flag register, aligned with rd_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_err_q <= 1'b0;
    end else begin
      rd_err_q <= rd_err_d;
    end
  end

  assign rd_err = rd_err_q;
`else
  logic unused_par_inv;
  assign unused_par_inv = wpar_inv;
  assign rd_err         = 1'b0;
`endif

endmodule

// File: rtl/dff_mem_burst.sv
// Clocked flip-flop memory behind a valid/ready command port, with an
// auto-incrementing pointer and a self-timed bulk CLEAR.
// Optional build macro: DFF_MEM_PARITY_EN (per-word parity, rd_err).
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | accepting commands, cmd_ready high
// ST_CLEARING | writing 0 to word clr_cnt each cycle, commands ignored
module dff_mem_burst #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              wr_par_inv,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              addr_err,
  output logic [ADDR_W-1:0] ptr,
  output logic              busy
);
  import dff_mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              addr_err_q, addr_err_d;

  logic              accept;
  cmd_op_e           op;
  logic [31:0]       cmd_data_ext;
  logic              addr_ok;
  logic [ADDR_W-1:0] ptr_inc;
  logic              clr_last;

  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [DATA_W-1:0] arr_wdata;
  logic              arr_par_inv;

  // cmd_ready comes straight from the state register, never from cmd_*.
  assign busy      = (state_q == ST_CLEARING);
  assign cmd_ready = ~busy;
  assign accept    = cmd_valid & cmd_ready;
  assign op        = cmd_op_e'(cmd_op);

  // The range check uses the whole data word, not just the pointer bits.
  assign cmd_data_ext = 32'(cmd_data);
  assign addr_ok      = cmd_data_ext < 32'(DEPTH);

  assign ptr_inc  = (ptr_q == ADDR_W'(DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
  assign clr_last = (clr_cnt_q == ADDR_W'(DEPTH - 1));

  // Next-state, pointer and error-pulse logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    clr_cnt_d  = clr_cnt_q;
    addr_err_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (op)
            OP_SET_ADDR: begin
              if (addr_ok) begin
                ptr_d = ADDR_W'(cmd_data);
              end else begin
                addr_err_d = 1'b1;
              end
            end
            OP_WRITE: ptr_d = ptr_inc;
            OP_READ:  ptr_d = ptr_inc;
            OP_CLEAR: begin
              state_d   = ST_CLEARING;
              clr_cnt_d = '0;
            end
            default: ;
          endcase
        end
      end
      ST_CLEARING: begin
        if (clr_last) begin
          state_d   = ST_IDLE;
          ptr_d     = '0;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage port steering: the clear sequencer owns the write port while busy.
  always_comb begin
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_waddr   = ptr_q;
    arr_wdata   = cmd_data;
    arr_par_inv = wr_par_inv;
    if (state_q == ST_CLEARING) begin
      arr_we      = 1'b1;
      arr_waddr   = clr_cnt_q;
      arr_wdata   = '0;
      arr_par_inv = 1'b0;
    end else if (accept) begin
      arr_we = (op == OP_WRITE);
      arr_re = (op == OP_READ);
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      clr_cnt_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      clr_cnt_q  <= clr_cnt_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign ptr      = ptr_q;
  assign addr_err = addr_err_q;

  dff_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .we       (arr_we),
    .waddr    (arr_waddr),
    .wdata    (arr_wdata),
    .wpar_inv (arr_par_inv),
    .re       (arr_re),
    .raddr    (ptr_q),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

endmodule
